// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit combinational ALU: valid/ready command in, registered ALU drive, captured result out.
// Optional macro ALU_SEQ_FLAGS_EN adds res_zero and carry_sticky outputs.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_src_acc,
  input  logic             cmd_wb_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             res_zero,
  output logic             carry_sticky,
`endif
  output logic [WIDTH-1:0] acc_q
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  logic   wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are loaded at accept and held until the next accept; result is captured after one ALU cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      wb_q      <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      acc_q     <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        alu_a   <= cmd_src_acc ? acc_q : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
        wb_q    <= cmd_wb_acc;
      end
      if (state_q == EXEC) begin
        res_data  <= alu_out;
        res_carry <= alu_carry;
        if (wb_q) acc_q <= alu_out;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // An AND written back to the accumulator restarts carry accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_zero     <= 1'b0;
      carry_sticky <= 1'b0;
    end else if (state_q == EXEC) begin
      res_zero <= (alu_out == '0);
      if (wb_q && alu_sel == SEL_W'(2)) carry_sticky <= 1'b0;
      else                              carry_sticky <= carry_sticky | alu_carry;
    end
  end
`endif

endmodule
